// File: rtl/ovf_dr_pkg.sv
// Shared dual-rail encodings, opcodes and helpers for the overflow detector.
package ovf_dr_pkg;

  typedef logic [1:0] dr_t;

  localparam dr_t DR_NULL = 2'b00;
  localparam dr_t DR_F    = 2'b01;
  localparam dr_t DR_T    = 2'b10;
  localparam dr_t DR_INV  = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

  // Per-lane decode result carried from the lane checker to the top.
  typedef struct packed {
    logic ovf;
    logic err;
  } lane_res_t;

  // True for a legal data codeword (TRUE or FALSE).
  function automatic logic dr_valid(input dr_t x);
    return (x == DR_T) || (x == DR_F);
  endfunction

  // Single-rail value of a legal codeword.
  function automatic logic dr_bit(input dr_t x);
    return x == DR_T;
  endfunction

endpackage

// File: rtl/ovf_lane_dr.sv
// Combinational signed-overflow and coding check for one ALU lane (MSBs only).
module ovf_lane_dr
  import ovf_dr_pkg::*;
(
  input  dr_t       a,
  input  dr_t       b,
  input  dr_t       res,
  input  logic      op_en,
  input  logic      op_sub,
  output lane_res_t res_c
);

  logic a_b;
  logic b_b;
  logic r_b;
  logic lane_err;

  // Lane is only trusted when all three pairs carry legal codewords.
  always_comb begin
    lane_err  = !dr_valid(a) || !dr_valid(b) || !dr_valid(res);
    a_b       = dr_bit(a);
    b_b       = dr_bit(b);
    r_b       = dr_bit(res);
    res_c.err = lane_err;
    res_c.ovf = op_en && !lane_err && (r_b != a_b) &&
                (op_sub ? (a_b != b_b) : (a_b == b_b));
  end

endmodule

// File: rtl/ovf_detector_dr.sv
// Multi-lane dual-rail overflow detector with valid/ready output register,
// sticky overflow flag and optional saturating event counter (OVF_COUNT_EN).
module ovf_detector_dr
  import ovf_dr_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*CH-1:0]   a_dr,
  input  logic [2*CH-1:0]   b_dr,
  input  logic [2*CH-1:0]   res_dr,
  input  logic [1:0]        sel0_dr,
  input  logic [1:0]        sel1_dr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*CH-1:0]   ovf_dr,
  output logic              ovf_any,
  output logic [CH:0]       code_err,
  input  logic              clr_sticky,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  ovf_cnt
);

  logic            accept;
  logic            op_err;
  logic [1:0]      opcode;
  logic            op_en;
  logic            op_sub;
  logic [CH-1:0]   lane_ovf;
  logic [CH-1:0]   lane_err;
  lane_res_t       lane_res [CH];

  logic            out_valid_q, out_valid_d;
  logic [2*CH-1:0] ovf_dr_q, ovf_dr_d;
  logic            ovf_any_q, ovf_any_d;
  logic [CH:0]     code_err_q, code_err_d;
  logic            sticky_q, sticky_d;

  // Opcode decode; an illegal opcode pair disables every lane.
  always_comb begin
    op_err = !dr_valid(sel0_dr) || !dr_valid(sel1_dr);
    opcode = {dr_bit(sel1_dr), dr_bit(sel0_dr)};
    op_en  = !op_err && ((opcode == OP_ADD) || (opcode == OP_SUB));
    op_sub = (opcode == OP_SUB);
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    ovf_lane_dr u_lane (
      .a      (dr_t'(a_dr[2*i +: 2])),
      .b      (dr_t'(b_dr[2*i +: 2])),
      .res    (dr_t'(res_dr[2*i +: 2])),
      .op_en  (op_en),
      .op_sub (op_sub),
      .res_c  (lane_res[i])
    );
    assign lane_ovf[i] = lane_res[i].ovf;
    assign lane_err[i] = lane_res[i].err;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register next state: load on accept, drop to NULL when drained.
  always_comb begin
    out_valid_d = out_valid_q;
    ovf_dr_d    = ovf_dr_q;
    ovf_any_d   = ovf_any_q;
    code_err_d  = code_err_q;
    sticky_d    = sticky_q;
    if (accept) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < CH; i++) begin
        ovf_dr_d[2*i +: 2] = lane_ovf[i] ? DR_T : DR_F;
      end
      ovf_any_d  = |lane_ovf;
      code_err_d = {op_err, lane_err};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
      ovf_dr_d    = {CH{DR_NULL}};
      ovf_any_d   = 1'b0;
      code_err_d  = '0;
    end
    if (accept && (|lane_ovf)) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  // Output and sticky registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ovf_dr_q    <= {CH{DR_NULL}};
      ovf_any_q   <= 1'b0;
      code_err_q  <= '0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ovf_dr_q    <= ovf_dr_d;
      ovf_any_q   <= ovf_any_d;
      code_err_q  <= code_err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign ovf_dr     = ovf_dr_q;
  assign ovf_any    = ovf_any_q;
  assign code_err   = code_err_q;
  assign ovf_sticky = sticky_q;

`ifdef OVF_COUNT_EN
  localparam int unsigned PC_W  = $clog2(CH + 1);
  localparam int unsigned SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] sum;

  // Saturating count of overflowing lanes; an increment beats a clear.
  always_comb begin
    pc = '0;
    for (int i = 0; i < CH; i++) begin
      pc = pc + PC_W'(lane_ovf[i]);
    end
    sum   = SUM_W'(cnt_q) + SUM_W'(pc);
    cnt_d = cnt_q;
    if (accept && (pc != '0)) begin
      cnt_d = (sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(sum);
    end else if (clr_sticky) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovf_cnt = cnt_q;
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_ovf_detector_dr.sv
// Directed, table-driven bench for ovf_detector_dr (CH=4, CNT_W=2).
module tb_ovf_detector_dr;

  localparam int unsigned CH    = 4;
  localparam int unsigned CNT_W = 2;
  localparam logic [1:0] T = 2'b10;
  localparam logic [1:0] F = 2'b01;
  localparam logic [1:0] N = 2'b00;
  localparam logic [1:0] X = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2*CH-1:0]   a_dr, b_dr, res_dr;
  logic [1:0]        sel0_dr, sel1_dr;
  logic              out_valid;
  logic              out_ready;
  logic [2*CH-1:0]   ovf_dr;
  logic              ovf_any;
  logic [CH:0]       code_err;
  logic              clr_sticky;
  logic              ovf_sticky;
  logic [CNT_W-1:0]  ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ovf_detector_dr #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_dr       (a_dr),
    .b_dr       (b_dr),
    .res_dr     (res_dr),
    .sel0_dr    (sel0_dr),
    .sel1_dr    (sel1_dr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf_dr     (ovf_dr),
    .ovf_any    (ovf_any),
    .code_err   (code_err),
    .clr_sticky (clr_sticky),
    .ovf_sticky (ovf_sticky),
    .ovf_cnt    (ovf_cnt)
  );

  typedef struct {
    logic [1:0] s1;
    logic [1:0] s0;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [7:0] eo;
    logic       ea;
    logic [4:0] ee;
  } vec_t;

  vec_t vt[8];
  vec_t v2ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld, input logic rdy, input logic clr);
    sel1_dr    = v.s1;
    sel0_dr    = v.s0;
    a_dr       = v.a;
    b_dr       = v.b;
    res_dr     = v.r;
    in_valid   = vld;
    out_ready  = rdy;
    clr_sticky = clr;
  endtask

  // Drive at negedge, clock it in, sample 1 time unit after the edge.
  task automatic step(input vec_t v, input logic vld, input logic rdy, input logic clr);
    @(negedge clk);
    drive(v, vld, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input vec_t v);
    check({name, ".valid"}, 32'(out_valid), 32'd1);
    check({name, ".ovf_dr"}, 32'(ovf_dr), 32'(v.eo));
    check({name, ".any"}, 32'(ovf_any), 32'(v.ea));
    check({name, ".err"}, 32'(code_err), 32'(v.ee));
  endtask

  function automatic int pop_t(input logic [7:0] eo);
    int c = 0;
    for (int i = 0; i < 4; i++) if (eo[2*i +: 2] == T) c++;
    return c;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_cnt;

  initial begin
    // {s1, s0, a, b, r, exp ovf, exp any, exp err}; lanes listed {3,2,1,0}
    vt[0] = '{F, F, {F,F,F,T}, {F,F,F,T}, {F,F,F,F}, {F,F,F,T}, 1'b1, 5'b00000};
    vt[1] = '{F, T, {F,F,F,F}, {F,T,F,F}, {F,T,F,F}, {F,T,F,F}, 1'b1, 5'b00000};
    vt[2] = '{F, F, {F,F,F,F}, {F,T,F,F}, {F,T,F,F}, {F,F,F,F}, 1'b0, 5'b00000};
    vt[3] = '{F, F, {F,F,T,T}, {F,F,T,T}, {F,F,X,F}, {F,F,F,T}, 1'b1, 5'b00010};
    vt[4] = '{F, N, {F,F,F,T}, {F,F,F,T}, {F,F,F,F}, {F,F,F,F}, 1'b0, 5'b10000};
    vt[5] = '{T, F, {F,F,F,T}, {F,F,F,T}, {F,F,F,F}, {F,F,F,F}, 1'b0, 5'b00000};
    vt[6] = '{F, F, {F,F,F,F}, {F,F,F,F}, {T,T,T,T}, {T,T,T,T}, 1'b1, 5'b00000};
    vt[7] = '{F, T, {T,F,F,N}, {F,F,F,F}, {F,F,F,F}, {T,F,F,F}, 1'b1, 5'b00001};
    v2ovf = '{F, F, {F,F,T,T}, {F,F,T,T}, {F,F,F,F}, {F,F,T,T}, 1'b1, 5'b00000};

    drive(vt[0], 1'b0, 1'b1, 1'b0);
    do_reset();
    #1;
    check("rst.valid",  32'(out_valid), 32'd0);
    check("rst.ovf_dr", 32'(ovf_dr), 32'd0);
    check("rst.any",    32'(ovf_any), 32'd0);
    check("rst.err",    32'(code_err), 32'd0);
    check("rst.sticky", 32'(ovf_sticky), 32'd0);
    check("rst.cnt",    32'(ovf_cnt), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);

    // Table: one accept per cycle, consumer always ready.
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(vt[i], 1'b1, 1'b1, 1'b0);
      check_out($sformatf("vec%0d", i), vt[i]);
      check($sformatf("vec%0d.sticky", i), 32'(ovf_sticky), 32'd1);
`ifdef OVF_COUNT_EN
      exp_cnt = exp_cnt + pop_t(vt[i].eo);
      if (exp_cnt > 3) exp_cnt = 3;
`endif
      check($sformatf("vec%0d.cnt", i), 32'(ovf_cnt), 32'(exp_cnt));
    end

    // Drain: output returns to NULL.
    step(vt[0], 1'b0, 1'b1, 1'b0);
    check("drain.valid",  32'(out_valid), 32'd0);
    check("drain.ovf_dr", 32'(ovf_dr), 32'd0);
    check("drain.any",    32'(ovf_any), 32'd0);

    // Sticky clear alone, then clear racing a new overflow.
    step(vt[0], 1'b0, 1'b1, 1'b1);
    check("clr.sticky", 32'(ovf_sticky), 32'd0);
    check("clr.cnt",    32'(ovf_cnt), 32'd0);
    step(vt[0], 1'b1, 1'b1, 1'b1);
    check("clrset.sticky", 32'(ovf_sticky), 32'd1);

    // Stall: load vt[0], hold consumer off for 3 cycles with vt[1] pending.
    step(vt[0], 1'b1, 1'b0, 1'b0);
    check_out("stall.load", vt[0]);
    for (int i = 0; i < 3; i++) begin
      step(vt[1], 1'b1, 1'b0, 1'b0);
      check($sformatf("stall%0d.in_ready", i), 32'(in_ready), 32'd0);
      check_out($sformatf("stall%0d", i), vt[0]);
    end
    step(vt[1], 1'b1, 1'b1, 1'b0);
    check_out("b2b0", vt[1]);
    step(vt[2], 1'b1, 1'b1, 1'b0);
    check_out("b2b1", vt[2]);
    step(vt[6], 1'b1, 1'b1, 1'b0);
    check_out("b2b2", vt[6]);

    // Counter saturation with 2 overflows per accept.
    drive(vt[0], 1'b0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(v2ovf, 1'b1, 1'b1, 1'b0);
`ifdef OVF_COUNT_EN
      exp_cnt = (i == 0) ? 2 : 3;
`else
      exp_cnt = 0;
`endif
      check($sformatf("sat%0d.cnt", i), 32'(ovf_cnt), 32'(exp_cnt));
      check($sformatf("sat%0d.ovf", i), 32'(ovf_dr), 32'(v2ovf.eo));
    end
    step(v2ovf, 1'b1, 1'b1, 1'b1);
    check("satclr.sticky", 32'(ovf_sticky), 32'd1);
    check("satclr.cnt",    32'(ovf_cnt), 32'(exp_cnt));
    step(v2ovf, 1'b0, 1'b1, 1'b1);
    check("clr2.sticky", 32'(ovf_sticky), 32'd0);
    check("clr2.cnt",    32'(ovf_cnt), 32'd0);

    // Asynchronous reset in the middle of a stall.
    step(v2ovf, 1'b1, 1'b0, 1'b0);
    check_out("pre_arst", v2ovf);
    check("pre_arst.sticky", 32'(ovf_sticky), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid",    32'(out_valid), 32'd0);
    check("arst.ovf_dr",   32'(ovf_dr), 32'd0);
    check("arst.any",      32'(ovf_any), 32'd0);
    check("arst.sticky",   32'(ovf_sticky), 32'd0);
    check("arst.cnt",      32'(ovf_cnt), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    step(v2ovf, 1'b0, 1'b1, 1'b0);
    check("post_arst.valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
